uart_rx_seq: RTL and testbench

UART_RX_SEQ -- requirements
Module: uart_rx_seq

---
 rtl/uart_rx_seq.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_seq.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_seq.sv
// UART receive sequencer: oversampled frame capture feeding an external
// parity/framing checker, with a valid/ready output and overrun flag.
module uart_rx_seq #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tick_16x,
    input  logic       rx,
    input  logic       parity_en,
    input  logic       parity_type,
    output logic       chk_start,
    output logic       chk_stop,
    output logic       chk_parity,
    output logic [7:0] chk_data,
    output logic       chk_en,
    input  logic       start_err,
    input  logic       stop_err,
    input  logic       data_err,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err_start,
    output logic       err_stop,
    output logic       err_parity,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        CHECK
    } state_t;

    state_t state;
    state_t state_nx;

    logic [SYNC_STAGES-1:0] sync;
    logic       rx_s;
    logic       rx_prev;
    logic       fall;
    logic [3:0] cnt;
    logic [2:0] idx;
    logic       mid;
    logic       last;
    logic       pen;
    logic       ptype;

    assign rx_s = sync[SYNC_STAGES-1];
    assign fall = rx_prev & ~rx_s;
    assign mid  = tick_16x && (cnt == 4'd7);
    assign last = tick_16x && (cnt == 4'd15);

    // Synchronizer idles high so reset never looks like a start edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync    <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], rx};
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        chk_en   = 1'b0;
        busy     = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (fall) state_nx = START;
            end
            START:  if (mid) state_nx = DATA;
            DATA: begin
                if (last && idx == 3'd7)
                    state_nx = pen ? PARITY : STOP;
            end
            PARITY: if (last) state_nx = STOP;
            STOP:   if (last) state_nx = CHECK;
            CHECK: begin
                chk_en   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt        <= '0;
            idx        <= '0;
            pen        <= 1'b0;
            ptype      <= 1'b0;
            chk_start  <= 1'b0;
            chk_stop   <= 1'b0;
            chk_parity <= 1'b0;
            chk_data   <= '0;
        end else begin
            if (state == IDLE || (state == START && mid))
                cnt <= '0;
            else if (tick_16x)
                cnt <= cnt + 4'd1;

            if (state == IDLE)
                idx <= '0;
            else if (state == DATA && last)
                idx <= idx + 3'd1;

            if (state == IDLE && fall) begin
                pen   <= parity_en;
                ptype <= parity_type;
            end

            if (state == START && mid)
                chk_start <= rx_s;
            if (state == DATA && last)
                chk_data[idx] <= rx_s;
            if (state == PARITY && last)
                chk_parity <= rx_s;
            if (state == STOP && last) begin
                chk_stop <= rx_s;
                // No parity bit on the wire: feed the checker a matching one
                if (!pen)
                    chk_parity <= (^chk_data) ^ ptype;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            err_start  <= 1'b0;
            err_stop   <= 1'b0;
            err_parity <= 1'b0;
            overrun    <= 1'b0;
        end else if (state == CHECK) begin
            out_data   <= chk_data;
            out_valid  <= 1'b1;
            err_start  <= start_err;
            err_stop   <= stop_err;
            err_parity <= data_err;
            if (out_valid && !out_ready)
                overrun <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_seq.sv
// Bench for uart_rx_seq: drives serial frames on a 16x tick grid and
// models the external parity checker plus expected frame results.
module tb_uart_rx_seq;

    logic       clk = 1'b0;
    logic       rstn;
    logic       tick_16x;
    logic       rx;
    logic       parity_en;
    logic       parity_type;
    logic       chk_start;
    logic       chk_stop;
    logic       chk_parity;
    logic [7:0] chk_data;
    logic       chk_en;
    logic       start_err;
    logic       stop_err;
    logic       data_err;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       err_start;
    logic       err_stop;
    logic       err_parity;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int tick_count = 0;
    int chk_seen = 0;
    int chk_tick = 0;
    int frame_tick = 0;
    logic [7:0] chk_last = '0;
    event tick_ev;

    uart_rx_seq dut (
        .clk(clk), .rstn(rstn), .tick_16x(tick_16x), .rx(rx),
        .parity_en(parity_en), .parity_type(parity_type),
        .chk_start(chk_start), .chk_stop(chk_stop),
        .chk_parity(chk_parity), .chk_data(chk_data),
        .chk_en(chk_en), .start_err(start_err),
        .stop_err(stop_err), .data_err(data_err),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .err_start(err_start),
        .err_stop(err_stop), .err_parity(err_parity),
        .overrun(overrun), .busy(busy)
    );

    // External checker: start must be 0, stop must be 1, parity per type
    assign start_err = chk_start;
    assign stop_err  = ~chk_stop;
    assign data_err  = (^chk_data) ^ chk_parity ^ parity_type;

    always #5 clk = ~clk;

    initial begin
        tick_16x = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 tick_16x = 1'b1;
            @(posedge clk);
            #1 tick_16x = 1'b0;
            tick_count++;
            -> tick_ev;
        end
    end

    always @(negedge clk) begin
        if (rstn && chk_en) begin
            chk_seen++;
            chk_tick = tick_count;
            chk_last = chk_data;
        end
    end

    task automatic send_frame(input logic [7:0] d, input bit pen,
                              input bit pb, input bit st,
                              input bit short_start, input int cut);
        logic [10:0] bits;
        int nb;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (pen) begin
            bits[9] = pb;
            bits[10] = st;
            nb = 11;
        end else begin
            bits[9] = st;
            nb = 10;
        end
        @(tick_ev);
        frame_tick = tick_count;
        for (int i = 0; i < nb; i++) begin
            rx = bits[i];
            for (int t = 0; t < 16; t++) begin
                if (cut > 0 && i * 16 + t == cut) return;
                if (i == 0 && short_start && t == 7) rx = 1'b1;
                @(tick_ev);
            end
        end
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        rx = 1'b1;
        out_ready = 1'b0;
        parity_en = 1'b0;
        parity_type = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset out_valid got %b want 0", out_valid);
        end
        checks++;
        if (busy !== 1'b0 || chk_en !== 1'b0) begin
            errors++;
            $display("FAIL reset busy/chk_en got %b%b want 00",
                     busy, chk_en);
        end
        checks++;
        if ({out_data, chk_data} !== 16'h0) begin
            errors++;
            $display("FAIL reset data got %h/%h want 00/00",
                     out_data, chk_data);
        end
        checks++;
        if ({err_start, err_stop, err_parity, overrun} !== 4'b0) begin
            errors++;
            $display("FAIL reset flags got %b%b%b%b want 0000",
                     err_start, err_stop, err_parity, overrun);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_frames();
        logic [7:0] td [6] = '{8'h17, 8'h17, 8'h17, 8'h17, 8'h17, 8'hA5};
        // {parity_en, parity_type, parity_bit, stop_bit, short_start}
        logic [4:0] tc [6] = '{5'b10010, 5'b11110, 5'b11010,
                               5'b10000, 5'b10011, 5'b00010};
        logic [7:0] d;
        logic pen, pt, pb, st, sh;
        bit e_s, e_t, e_p;
        int n0, rel, eb;
        for (int i = 0; i < 22; i++) begin
            if (i < 6) begin
                d = td[i];
                {pen, pt, pb, st, sh} = tc[i];
            end else begin
                d = 8'($urandom);
                pen = 1'($urandom);
                pt = 1'($urandom);
                pb = 1'($countones(d) % 2) ^ pt;
                if ($urandom_range(0, 2) == 0) pb = ~pb;
                st = ($urandom_range(0, 3) != 0);
                sh = ($urandom_range(0, 4) == 0);
            end
            parity_en = pen;
            parity_type = pt;
            n0 = chk_seen;
            send_frame(d, pen, pb, st, sh, 0);
            e_s = sh;
            e_t = !st;
            e_p = pen && ((($countones(d) + pb) % 2) != pt);
            eb = pen ? 10 : 9;
            rel = chk_tick - frame_tick;
            checks++;
            if (chk_seen != n0 + 1) begin
                errors++;
                $display("FAIL f%0d chk_en pulses got %0d want 1",
                         i, chk_seen - n0);
            end
            checks++;
            if (chk_last !== d) begin
                errors++;
                $display("FAIL f%0d chk_data got %h want %h",
                         i, chk_last, d);
            end
            checks++;
            if (rel < eb * 16 || rel >= eb * 16 + 16) begin
                errors++;
                $display("FAIL f%0d check tick got %0d want %0d..%0d",
                         i, rel, eb * 16, eb * 16 + 15);
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== d) begin
                errors++;
                $display("FAIL f%0d out got v%b %h want v1 %h",
                         i, out_valid, out_data, d);
            end
            checks++;
            if ({err_start, err_stop, err_parity} !== {e_s, e_t, e_p}) begin
                errors++;
                $display("FAIL f%0d errs got %b%b%b want %b%b%b", i,
                         err_start, err_stop, err_parity, e_s, e_t, e_p);
            end
            @(negedge clk);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL f%0d consume out_valid got %b want 0",
                         i, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        parity_en = 1'b1;
        parity_type = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        checks++;
        if (out_data !== 8'h22 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b out got v%b %h want v1 22",
                     out_valid, out_data);
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL b2b overrun got %b want 1", overrun);
        end
        @(negedge clk);
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b pre-transfer valid got %b want 1",
                     out_valid);
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL b2b after transfer v/ovr got %b%b want 01",
                     out_valid, overrun);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        parity_en = 1'b1;
        parity_type = 1'b0;
        send_frame(8'h96, 1'b1, 1'b0, 1'b1, 1'b0, 84);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midframe busy got %b want 1", busy);
        end
        rstn = 1'b0;
        rx = 1'b1;
        #1;
        checks++;
        if ({out_valid, busy, chk_en, overrun} !== 4'b0 ||
            chk_data !== 8'h0 || out_data !== 8'h0) begin
            errors++;
            $display("FAIL midreset v/b/en/ovr %b%b%b%b data %h/%h want 0",
                     out_valid, busy, chk_en, overrun, chk_data, out_data);
        end
        repeat (8) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        n0 = chk_seen;
        repeat (40) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || chk_seen != n0) begin
            errors++;
            $display("FAIL midreset stray frame v%b pulses %0d want 0",
                     out_valid, chk_seen - n0);
        end
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C ||
            {err_start, err_stop, err_parity} !== 3'b0) begin
            errors++;
            $display("FAIL post-reset frame v%b %h errs %b%b%b want v1 3c 000",
                     out_valid, out_data, err_start, err_stop, err_parity);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_same_cycle();
        bit found;
        found = 1'b0;
        out_ready = 1'b0;
        parity_en = 1'b0;
        parity_type = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        fork
            send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 0);
            begin
                for (int c = 0; c < 3000 && !found; c++) begin
                    @(negedge clk);
                    if (chk_en) begin
                        out_ready = 1'b1;
                        @(posedge clk);
                        #1 out_ready = 1'b0;
                        found = 1'b1;
                    end
                end
            end
        join
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL same-cycle chk_en timeout got 0 want 1");
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hC3 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL same-cycle v/data/ovr got %b %h %b want 1 c3 0",
                     out_valid, out_data, overrun);
        end
        checks++;
        if ({err_start, err_stop, err_parity} !== 3'b0) begin
            errors++;
            $display("FAIL same-cycle errs got %b%b%b want 000",
                     err_start, err_stop, err_parity);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frames();
        test_back_to_back();
        test_reset_mid();
        test_same_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
